// File: rtl/occurrence_walker.sv
// rtl/occurrence_walker.sv - streams a falsified literal's clause indices into the clause table
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module occurrence_walker #(
  parameter int VAR_BITS      = 8,
  parameter int OCC_ADDR_BITS = 12,
  parameter int CLAUSE_BITS   = `MAX_CLAUSES_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     lit_valid,
  input  logic [VAR_BITS-1:0]      lit_var,
  input  logic                     lit_pol,
  output logic                     lit_ready,
  output logic                     hdr_rd_en,
  output logic [VAR_BITS:0]        hdr_addr,
  input  logic [OCC_ADDR_BITS-1:0] hdr_start,
  input  logic [CLAUSE_BITS-1:0]   hdr_count,
  output logic                     occ_rd_en,
  output logic [OCC_ADDR_BITS-1:0] occ_addr,
  input  logic [CLAUSE_BITS-1:0]   occ_data,
  output logic                     tbl_push,
  output logic [CLAUSE_BITS-1:0]   tbl_clause,
  input  logic                     tbl_full,
  output logic                     done,
  output logic [CLAUSE_BITS-1:0]   pushed_count,
  output logic                     overflow
);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, STREAM, DONE} state_t;

  state_t                   state;
  logic [VAR_BITS:0]        lit_q;
  logic [OCC_ADDR_BITS-1:0] ptr;
  logic [CLAUSE_BITS-1:0]   remaining;
  logic                     pend;
  logic                     reject;

  // Returning data meets a full table: drop it and stop issuing in the same cycle.
  assign reject     = (state == STREAM) && pend && tbl_full;

  assign lit_ready  = (state == IDLE);
  assign hdr_rd_en  = (state == HDR);
  assign hdr_addr   = lit_q;
  assign occ_rd_en  = (state == STREAM) && (remaining != '0) && !reject;
  assign occ_addr   = ptr;
  assign tbl_push   = (state == STREAM) && pend && !tbl_full;
  assign tbl_clause = tbl_push ? occ_data : '0;
  assign done       = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lit_q        <= '0;
      ptr          <= '0;
      remaining    <= '0;
      pend         <= 1'b0;
      pushed_count <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lit_valid) begin
            lit_q        <= {lit_var, ~lit_pol};
            pushed_count <= '0;
            overflow     <= 1'b0;
            state        <= HDR;
          end
        end
        HDR: state <= LOAD;
        LOAD: begin
          ptr       <= hdr_start;
          remaining <= hdr_count;
          pend      <= 1'b0;
          state     <= (hdr_count == '0) ? DONE : STREAM;
        end
        STREAM: begin
          pend <= occ_rd_en;
          if (occ_rd_en) begin
            ptr       <= ptr + OCC_ADDR_BITS'(1);
            remaining <= remaining - CLAUSE_BITS'(1);
          end
          if (tbl_push)
            pushed_count <= pushed_count + CLAUSE_BITS'(1);
          // remaining==0 here means the only read left in flight is the one being consumed now.
          if (reject) begin
            overflow <= 1'b1;
            state    <= DONE;
          end else if (remaining == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          pend  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occurrence_walker.sv
// tb/tb_occurrence_walker.sv - randomized and directed checks of occurrence_walker against a behavioural model
module tb_occurrence_walker;
  localparam int VB = 8;
  localparam int AB = 12;
  localparam int CB = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          lit_valid = 1'b0;
  logic [VB-1:0] lit_var = '0;
  logic          lit_pol = 1'b0;
  logic          lit_ready, hdr_rd_en, occ_rd_en, tbl_push, done, overflow;
  logic [VB:0]   hdr_addr;
  logic [AB-1:0] hdr_start = '0;
  logic [CB-1:0] hdr_count = '0;
  logic [AB-1:0] occ_addr;
  logic [CB-1:0] occ_data = '0;
  logic [CB-1:0] tbl_clause, pushed_count;
  logic          tbl_full = 1'b0;

  occurrence_walker #(.VAR_BITS(VB), .OCC_ADDR_BITS(AB), .CLAUSE_BITS(CB)) dut (
    .clock(clock), .reset(reset),
    .lit_valid(lit_valid), .lit_var(lit_var), .lit_pol(lit_pol), .lit_ready(lit_ready),
    .hdr_rd_en(hdr_rd_en), .hdr_addr(hdr_addr), .hdr_start(hdr_start), .hdr_count(hdr_count),
    .occ_rd_en(occ_rd_en), .occ_addr(occ_addr), .occ_data(occ_data),
    .tbl_push(tbl_push), .tbl_clause(tbl_clause), .tbl_full(tbl_full),
    .done(done), .pushed_count(pushed_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  logic [CB-1:0] occ_mem [0:4095];
  logic [AB-1:0] hs_mem  [0:511];
  logic [CB-1:0] hc_mem  [0:511];
  int            tbl_cap = 1000;
  int            tbl_cnt = 0;
  logic          tbl_clr = 1'b0;
  int            cyc = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (hdr_rd_en) begin
      hdr_start <= hs_mem[hdr_addr];
      hdr_count <= hc_mem[hdr_addr];
    end
    if (occ_rd_en) occ_data <= occ_mem[occ_addr];
    if (tbl_clr) begin
      tbl_cnt  <= 0;
      tbl_full <= 1'b0;
    end else if (tbl_push) begin
      tbl_cnt  <= tbl_cnt + 1;
      tbl_full <= (tbl_cnt + 1 >= tbl_cap);
    end
  end

  typedef struct {int c; int v;} ev_t;
  ev_t push_q[$];
  ev_t rd_q[$];
  int  acc_cyc = -1, hdr_hits = 0, hdr_rel = -1, hdr_val = -1;
  int  ready_hi = 0, fin_ready_hi = 0, done_cnt = 0, done_rel = -1, done_abs = -1;
  int  fin_pc = -1, fin_ov = -1, viol = 0;
  bit  in_walk = 0;

  always @(negedge clock) begin
    if (reset) begin
      in_walk = 0;
    end else begin
      if (lit_valid && lit_ready) begin
        acc_cyc = cyc; push_q.delete(); rd_q.delete();
        hdr_hits = 0; ready_hi = 0; in_walk = 1;
      end else if (in_walk && lit_ready) begin
        ready_hi++;
      end
      if (hdr_rd_en) begin hdr_hits++; hdr_rel = cyc - acc_cyc; hdr_val = int'(hdr_addr); end
      if (occ_rd_en) rd_q.push_back('{cyc - acc_cyc, int'(occ_addr)});
      if (tbl_push) push_q.push_back('{cyc - acc_cyc, int'(tbl_clause)});
      if (tbl_push && tbl_full) viol++;
      if (done) begin
        done_cnt++; done_rel = cyc - acc_cyc; done_abs = cyc;
        fin_pc = int'(pushed_count); fin_ov = int'(overflow);
        fin_ready_hi = ready_hi; in_walk = 0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_walk(input int v, input int p, input int start, input int count, input int cap);
    int lit;
    int drive_c;
    int n;
    lit = v * 2 + (p != 0 ? 0 : 1);
    hs_mem[lit] = AB'(start);
    hc_mem[lit] = CB'(count);
    n = 0;
    while (!lit_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    tbl_cap = cap; tbl_clr = 1'b1;
    lit_valid = 1'b1; lit_var = VB'(v); lit_pol = (p != 0);
    drive_c = cyc;
    @(posedge clock); #1;
    tbl_clr = 1'b0; lit_valid = 1'b0;
    check("accept_cycle", acc_cyc, drive_c);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clock); #1; n++; end
    check({tag, "_done_seen"}, done_cnt, d0 + 1);
  endtask

  task automatic run_walk(input int v, input int p, input int start, input int count, input int cap, input string tag);
    int d0, e_push, e_ov, e_rd, e_done, lit;
    d0 = done_cnt;
    lit = v * 2 + (p != 0 ? 0 : 1);
    e_push = (count < cap) ? count : cap;
    e_ov   = (count > cap) ? 1 : 0;
    e_rd   = e_ov ? cap + 1 : count;
    e_done = (count == 0) ? 3 : (e_ov ? cap + 5 : count + 4);
    start_walk(v, p, start, count, cap);
    wait_done(d0, tag);
    check({tag, "_done_cycle"}, done_rel, e_done);
    check({tag, "_pushed_count"}, fin_pc, e_push);
    check({tag, "_overflow"}, fin_ov, e_ov);
    check({tag, "_num_pushes"}, push_q.size(), e_push);
    check({tag, "_num_reads"}, rd_q.size(), e_rd);
    check({tag, "_hdr_reads"}, hdr_hits, 1);
    check({tag, "_hdr_cycle"}, hdr_rel, 1);
    check({tag, "_hdr_addr"}, hdr_val, lit);
    check({tag, "_ready_low"}, fin_ready_hi, 0);
    check({tag, "_push_while_full"}, viol, 0);
    for (int i = 0; i < push_q.size() && i < e_push; i++) begin
      check({tag, "_push_val"}, push_q[i].v, int'(occ_mem[(start + i) % 4096]));
      check({tag, "_push_cyc"}, push_q[i].c, 4 + i);
    end
    for (int i = 0; i < rd_q.size() && i < e_rd; i++) begin
      check({tag, "_rd_addr"}, rd_q[i].v, (start + i) % 4096);
      check({tag, "_rd_cyc"}, rd_q[i].c, 3 + i);
    end
  endtask

  initial begin
    int d0, d_first, n;
    for (int i = 0; i < 4096; i++) occ_mem[i] = CB'($urandom_range(0, 255));
    for (int i = 0; i < 512; i++) begin hs_mem[i] = '0; hc_mem[i] = '0; end

    repeat (3) @(posedge clock);
    #1;
    check("reset_lit_ready", int'(lit_ready), 1);
    check("reset_outputs_zero",
          int'({hdr_rd_en, hdr_addr, occ_rd_en, occ_addr, tbl_push, tbl_clause, done, pushed_count, overflow}), 0);
    reset = 1'b0;

    occ_mem[20] = 8'd7; occ_mem[21] = 8'd9; occ_mem[22] = 8'd12;
    run_walk(5, 1, 20, 3, 1000, "basic");
    run_walk(17, 0, 100, 0, 1000, "empty");
    run_walk(33, 1, 300, 4, 2, "overflow");
    run_walk(2, 0, 4094, 3, 1000, "wrap");
    run_walk(40, 1, 500, 5, 5, "exact_fill");

    for (int k = 0; k < 8; k++)
      run_walk($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 4095),
               $urandom_range(0, 10), $urandom_range(1, 12), "random");

    // back-to-back: literal held valid through the first walk
    hs_mem[60 * 2] = AB'(50); hc_mem[60 * 2] = CB'(2);
    hs_mem[61 * 2 + 1] = AB'(70); hc_mem[61 * 2 + 1] = CB'(1);
    d0 = done_cnt;
    @(posedge clock); #1;
    tbl_cap = 1000; tbl_clr = 1'b1; lit_valid = 1'b1; lit_var = VB'(60); lit_pol = 1'b1;
    @(posedge clock); #1;
    tbl_clr = 1'b0; lit_var = VB'(61); lit_pol = 1'b0;
    wait_done(d0, "b2b_first");
    d_first = done_abs;
    check("b2b_first_ready_low", fin_ready_hi, 0);
    check("b2b_first_pushed", fin_pc, 2);
    repeat (2) @(posedge clock);
    #1;
    check("b2b_second_accept", acc_cyc, d_first + 1);
    lit_valid = 1'b0;
    wait_done(d0 + 1, "b2b_second");
    check("b2b_second_hdr_addr", hdr_val, 61 * 2 + 1);
    check("b2b_second_pushed", fin_pc, 1);

    // reset after the first push of a 5-entry walk
    d0 = done_cnt;
    start_walk(80, 1, 900, 5, 1000);
    n = 0;
    while (push_q.size() < 1 && n < 50) begin @(posedge clock); #1; n++; end
    check("rst_first_push_seen", push_q.size() >= 1 ? 1 : 0, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_lit_ready", int'(lit_ready), 1);
    check("rst_outputs_zero",
          int'({hdr_rd_en, hdr_addr, occ_rd_en, occ_addr, tbl_push, tbl_clause, done, pushed_count, overflow}), 0);
    repeat (10) @(posedge clock);
    #1;
    check("rst_no_done", done_cnt, d0);
    run_walk(81, 0, 1000, 4, 1000, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/occurrence_walker.md
Name: occurrence_walker

Overview:
- Upstream feeder of the clause table in the BCP datapath.
- On each variable assignment from the decision/implication unit, fetches the occurrence-list header for the literal that was falsified.
- Streams that literal's clause indices from occurrence memory and pushes them into the clause table one per cycle.
- Reports the count pushed and any table overflow, so the clause evaluator knows how many entries to read.

Parameters:
VAR_BITS, 8, variable index width
OCC_ADDR_BITS, 12, occurrence-memory address width
CLAUSE_BITS, `MAX_CLAUSES_BITS, clause index width (matches clause table entries)

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high; clock clock
lit_valid  in  1  assignment available
lit_var  in  VAR_BITS  assigned variable
lit_pol  in  1  assigned value (1 = true)
lit_ready  out  1  walker idle, accepts assignment
hdr_rd_en  out  1  header memory read strobe
hdr_addr  out  VAR_BITS+1  {lit_var, ~lit_pol}, the falsified literal
hdr_start  in  OCC_ADDR_BITS  first occurrence entry (valid 1 cycle after hdr_rd_en)
hdr_count  in  CLAUSE_BITS  number of occurrence entries
occ_rd_en  out  1  occurrence memory read strobe
occ_addr  out  OCC_ADDR_BITS  occurrence entry address
occ_data  in  CLAUSE_BITS  clause index (valid 1 cycle after occ_rd_en)
tbl_push  out  1  push to clause table
tbl_clause  out  CLAUSE_BITS  clause index pushed
tbl_full  in  1  clause table full
done  out  1  one-cycle completion pulse
pushed_count  out  CLAUSE_BITS  entries pushed for this literal
overflow  out  1  table filled before list exhausted

Behaviour:
- FSM states: IDLE, HDR, LOAD, STREAM, DONE.
- Reset: state IDLE. lit_ready=1. All other outputs 0, including pushed_count and overflow. Internal counters cleared.
- Reset mid-operation: abandons the walk. No further reads or pushes. No done pulse.
- IDLE:
  - lit_ready=1.
  - When lit_valid=1 (cycle 0), latch {lit_var, ~lit_pol}, clear pushed_count and overflow, go to HDR.
- HDR (cycle 1):
  - hdr_rd_en=1, hdr_addr=latched literal.
  - Go to LOAD.
- LOAD (cycle 2):
  - Capture hdr_start into the read pointer and hdr_count into the remaining counter.
  - If count==0, go to DONE; otherwise go to STREAM.
- STREAM:
  - Issue side: while remaining>0 and no stop, occ_rd_en=1 with occ_addr=pointer. Then pointer+1 (modulo 2^OCC_ADDR_BITS, wraps) and remaining-1.
  - Result side: a 1-bit valid flag delayed one cycle marks returning data.
  - When the flag is set and tbl_full=0: tbl_push=1, tbl_clause=occ_data, pushed_count+1.
  - When the flag is set and tbl_full=1: no push, overflow=1, stop. No further occ_rd_en; any in-flight read result is discarded.
  - Leave STREAM when remaining==0 and no read in flight, or on stop. Go to DONE.
- Timing, count N with no overflow: reads in cycles 3..N+2, pushes in cycles 4..N+3, done in cycle N+4. For N=0, done in cycle 3.
- DONE:
  - done=1 for exactly one cycle. lit_ready=0.
  - Next state IDLE.
  - pushed_count and overflow hold their values until the next assignment is accepted.
- lit_ready is 1 only in IDLE. A literal held valid during a walk is accepted in the cycle after done.
- Push rules:
  - tbl_push is never asserted while tbl_full=1.
  - At most one push per cycle.
  - The table's full flag lags the filling push by one cycle; the walker relies on this lag and does no capacity tracking of its own.
- Arithmetic:
  - remaining and pushed_count are CLAUSE_BITS wide and unsigned.
  - hdr_count is trusted to be at most 2^CLAUSE_BITS-1.

Test Plan:
- Basic walk: var=5, pol=1 -> hdr_addr=10 in cycle 1. Header returns start=20, count=3; occ[20..22]=7,9,12. Required: pushes 7, 9, 12 in cycles 4, 5, 6; done in cycle 7 with pushed_count=3, overflow=0.
- Empty list: count=0 -> no occ_rd_en and no push; done in cycle 3 with pushed_count=0.
- Overflow: count=4, tbl_full rises after the 2nd push -> exactly 2 pushes, overflow=1, pushed_count=2. No occ_rd_en after full is observed; done asserts.
- Address wrap: OCC_ADDR_BITS=12, start=4094, count=3 -> occ_addr sequence 4094, 4095, 0.
- Back-to-back: lit_valid held with two literals -> second accepted in the cycle after the first done; lit_ready=0 throughout the first walk.
- Reset mid-stream: assert reset after the 1st push of 5 -> next cycle lit_ready=1, all other outputs 0; no done; a fresh walk afterwards completes normally.
